// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - state_t     : responder FSM encoding (IDLE / WAIT / RESP)
//   - CNT_W       : width of the wait-state counter
//   - dbg_t       : debug view of FSM state, wait counter and latched PC
//   - merge_bytes : byte-lane merge used by the store path
package dm_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  typedef struct packed {
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pc;
  } dbg_t;

  // Lanes with be[i]=1 take new_word lane i, all other lanes keep old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Memory-stage load/store bus between the pipeline (master) and the
// data-memory responder (slave).
//   request : req_valid, req_ready, req_we, req_addr, req_be, req_wdata, req_pc
//   response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. Once valid is raised, the sender keeps valid and its payload
// stable until that edge; ready may be raised or lowered at any time.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_responder_array.sv
// dm_array: word storage for the data-memory responder.
//   clk, reset : clock, synchronous active-low reset (clears every word)
//   i_we       : write strobe
//   i_addr     : word address, shared by the write and read ports
//   i_be       : byte enables for the write
//   i_wdata    : lane-aligned write data
//   o_rdata    : asynchronous read of the addressed word
module dm_array
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < (1 << ADDR_W); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= merge_bytes(r_mem[i_addr], i_wdata, i_be);
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dm_responder.sv
// dm_responder: data-memory slave with a fixed number of wait states.
//   clk, reset : clock, synchronous active-low reset
//   bus        : dm_responder_if.slave (request and response handshakes)
//   o_dbg      : FSM state, wait counter and latched PC
// Parameters: ADDR_W (word-address width), WAIT_CYCLES (0..15).
// Optional macro DM_TRACE_EN: prints one line per committed non-error store.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dm_responder_if.slave        bus,
  output dbg_t                 o_dbg
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready, r_rsp_valid, r_rsp_err;
  logic [31:0]      r_rsp_rdata;
  logic             r_we;
  logic [31:0]      r_addr, r_wdata, r_pc;
  logic [3:0]       r_be;

  logic             w_accept, w_commit, w_err, w_mem_we;
  logic             w_c_we;
  logic [31:0]      w_c_addr, w_c_wdata;
  logic [3:0]       w_c_be;
  logic [31:0]      w_rd_word;

  // With zero wait states the commit edge is the acceptance edge, so the
  // commit path must see the live request rather than the latch.
  assign w_c_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
  assign w_c_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_c_be    = (r_state == ST_IDLE) ? bus.req_be    : r_be;
  assign w_c_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

  assign w_err    = (w_c_addr[1:0] != 2'b00) || (w_c_addr[31:ADDR_W+2] != '0);
  assign w_mem_we = w_commit && !w_err && w_c_we;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_req_ready && bus.req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next_state = ST_RESP;
            w_commit     = 1'b1;
          end else begin
            w_next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = ST_RESP;
          w_commit     = 1'b1;
        end
      end
      ST_RESP: begin
        if (r_rsp_valid && bus.rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_pc        <= '0;
    end else begin
      r_state     <= w_next_state;
      // Handshake outputs are registered copies of the next-state decode.
      r_req_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= (w_next_state == ST_RESP);
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_be    <= bus.req_be;
        r_wdata <= bus.req_wdata;
        r_pc    <= bus.req_pc;
        r_cnt   <= WAIT_LD;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || w_c_we) ? 32'h0 : w_rd_word;
      end
    end
  end

  dm_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_mem_we),
    .i_addr  (w_c_addr[ADDR_W+1:2]),
    .i_be    (w_c_be),
    .i_wdata (w_c_wdata),
    .o_rdata (w_rd_word)
  );

`ifdef DM_TRACE_EN
  logic [31:0] w_c_pc;
  assign w_c_pc = (r_state == ST_IDLE) ? bus.req_pc : r_pc;

  always_ff @(posedge clk) begin
    if (reset && w_mem_we) begin
      $display("%d@%h: *%h <= %h", $time, w_c_pc, {w_c_addr[31:2], 2'b00},
               merge_bytes(w_rd_word, w_c_wdata, w_c_be));
    end
  end
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign o_dbg         = {r_state, r_cnt, r_pc};

endmodule
